// File: rtl/tt_arith_pkg.sv
// tt_arith_pkg: shared op codes, FSM state encoding and sizing helper for the arithmetic unit
package tt_arith_pkg;
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_MUL = 1'b0;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/shift_add_mul_step.sv
// shift_add_mul_step: one radix-2 shift-add iteration, next accumulator and shifted multiplier
module shift_add_mul_step
  import tt_arith_pkg::*;
#(
  parameter int WIDTH = 3,
  localparam int RES_W = 2 * WIDTH,
  localparam int CW = clog2(WIDTH)
) (
  input  logic [RES_W-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [CW-1:0]    cnt_i,
  output logic [RES_W-1:0] acc_o,
  output logic [WIDTH-1:0] mplier_o
);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
  logic [RES_W-1:0] pp;
  // partial product weighted by the bit position currently at mplier[0]
  always_comb begin
    pp = RES_W'(mcand_i) << (CMAX - cnt_i);
    acc_o = mplier_i[0] ? acc_i + pp : acc_i;
    mplier_o = mplier_i >> 1;
  end
endmodule

// File: rtl/seq_add_mul_unit.sv
// seq_add_mul_unit: single-cycle add or WIDTH-cycle shift-add multiply behind valid/ready handshakes
module seq_add_mul_unit
  import tt_arith_pkg::*;
#(
  parameter int WIDTH = 3,
  localparam int RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             busy
);
  localparam int CW = clog2(WIDTH);
  state_t state_q;
  logic [RES_W-1:0] acc_q, acc_d, result_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, mplier_d;
  logic [CW-1:0] cnt_q;

  shift_add_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i(acc_q),
    .mcand_i(mcand_q),
    .mplier_i(mplier_q),
    .cnt_i(cnt_q),
    .acc_o(acc_d),
    .mplier_o(mplier_d)
  );

  // control FSM and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q <= '0;
      result_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (in_valid) begin
            if (op == OP_ADD) begin
              result_q <= RES_W'({1'b0, a} + {1'b0, b});
              state_q <= ST_DONE;
            end else begin
              mcand_q <= a;
              mplier_q <= b;
              acc_q <= '0;
              cnt_q <= CW'(WIDTH - 1);
              state_q <= ST_MUL;
            end
          end
        ST_MUL: begin
          acc_q <= acc_d;
          mplier_q <= mplier_d;
          if (cnt_q == '0) begin
            result_q <= acc_d;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DONE: if (out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign busy = state_q != ST_IDLE;
  assign result = result_q;
endmodule
